// File: rtl/ctrl_pkg.sv
// Shared controller definitions: 2-bit state encoding and a constant-width helper.
package ctrl_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StOperate = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  // Ceiling log2; clog2(1) is 0 so callers add one bit of headroom.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Up-counter with synchronous clear, enable and a terminal-value flag.
module step_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LAST  = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(LAST));

endmodule

// File: rtl/operand_sequencer.sv
// Issues one-hot operand capture strobes, then an op burst, then a result-valid
// indication (pulsed or held until ack), with abort and busy.
module operand_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 4,
  parameter int unsigned OP_CYCLES    = 1,
  parameter int unsigned HOLD_VALID   = 0
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    ack,
  output logic [NUM_OPERANDS-1:0] capture,
  output logic                    op,
  output logic                    op_last,
  output logic                    valid,
  output logic                    busy
);

  localparam int unsigned IdxW = clog2(NUM_OPERANDS) + 1;
  localparam int unsigned OpW  = clog2(OP_CYCLES) + 1;

  logic [1:0]              state_q, state_d;
  logic [IdxW-1:0]         idx;
  logic [OpW-1:0]          opcnt;
  logic                    idx_last, opcnt_last;
  logic                    idx_en, opcnt_en;
  logic [NUM_OPERANDS-1:0] capture_raw;
  logic                    op_raw, op_last_raw, valid_raw, busy_raw;
  logic                    unused_opcnt;

  assign unused_opcnt = ^opcnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters hold zero unless advancing, so every state entry starts from zero.
  step_counter #(
    .WIDTH (IdxW),
    .LAST  (NUM_OPERANDS - 1)
  ) u_idx (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (!idx_en),
    .enable (idx_en),
    .count  (idx),
    .last   (idx_last)
  );

  step_counter #(
    .WIDTH (OpW),
    .LAST  (OP_CYCLES - 1)
  ) u_opcnt (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (!opcnt_en),
    .enable (opcnt_en),
    .count  (opcnt),
    .last   (opcnt_last)
  );

  always_comb begin
    state_d     = state_q;
    capture_raw = '0;
    op_raw      = 1'b0;
    op_last_raw = 1'b0;
    valid_raw   = 1'b0;
    busy_raw    = 1'b0;
    idx_en      = 1'b0;
    opcnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          capture_raw[0] = 1'b1;
          if (NUM_OPERANDS == 1) begin
            state_d = StOperate;
          end else begin
            state_d = StCapture;
            idx_en  = 1'b1;
          end
        end
      end
      StCapture: begin
        busy_raw = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
            capture_raw[i] = (idx == IdxW'(i));
          end
          if (idx_last) state_d = StOperate;
          else          idx_en  = 1'b1;
        end
      end
      StOperate: begin
        busy_raw = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          op_raw      = 1'b1;
          op_last_raw = opcnt_last;
          if (opcnt_last) state_d  = StDone;
          else            opcnt_en = 1'b1;
        end
      end
      StDone: begin
        busy_raw = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          valid_raw = 1'b1;
          if (HOLD_VALID == 0 || ack) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gates every output, including the Mealy capture path from start.
  assign capture = capture_raw & {NUM_OPERANDS{rst_n}};
  assign op      = op_raw      & rst_n;
  assign op_last = op_last_raw & rst_n;
  assign valid   = valid_raw   & rst_n;
  assign busy    = busy_raw    & rst_n;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: three configurations checked every cycle against
// a sequence-offset timeline model, plus directed boundary steps.
module tb_operand_sequencer;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  start_v, abort_v, ack_v;
  logic [3:0]  cap0;
  logic [5:0]  cap1;
  logic [0:0]  cap2;
  logic [2:0]  op_w, last_w, valid_w, busy_w;
  logic [15:0] cap_o [3];

  assign cap_o[0] = {12'd0, cap0};
  assign cap_o[1] = {10'd0, cap1};
  assign cap_o[2] = {15'd0, cap2};

  operand_sequencer #(.NUM_OPERANDS(4), .OP_CYCLES(1), .HOLD_VALID(0)) dut0 (
    .clock(clock), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .ack(ack_v[0]),
    .capture(cap0), .op(op_w[0]), .op_last(last_w[0]), .valid(valid_w[0]), .busy(busy_w[0])
  );
  operand_sequencer #(.NUM_OPERANDS(6), .OP_CYCLES(3), .HOLD_VALID(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .ack(ack_v[1]),
    .capture(cap1), .op(op_w[1]), .op_last(last_w[1]), .valid(valid_w[1]), .busy(busy_w[1])
  );
  operand_sequencer #(.NUM_OPERANDS(1), .OP_CYCLES(1), .HOLD_VALID(0)) dut2 (
    .clock(clock), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .ack(ack_v[2]),
    .capture(cap2), .op(op_w[2]), .op_last(last_w[2]), .valid(valid_w[2]), .busy(busy_w[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pn [3] = '{4, 6, 1};
  int pc [3] = '{1, 3, 1};
  int ph [3] = '{0, 1, 0};
  // Offset of the current cycle from the accepted start; -1 when idle.
  int phase [3];

  function automatic logic [15:0] b16(input logic b);
    return {15'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] ec;
      logic eo, el, ev, eb;
      ec = '0; eo = 1'b0; el = 1'b0; ev = 1'b0;
      eb = (phase[i] >= 0);
      if (phase[i] < 0) begin
        if (start_v[i] && !abort_v[i]) ec = 16'd1;
      end else if (!abort_v[i]) begin
        if (phase[i] < pn[i]) begin
          ec = 16'd1 << phase[i];
        end else if (phase[i] < pn[i] + pc[i]) begin
          eo = 1'b1;
          el = (phase[i] == pn[i] + pc[i] - 1);
        end else begin
          ev = 1'b1;
        end
      end
      chk($sformatf("d%0d capture", i), cap_o[i], ec);
      chk($sformatf("d%0d op", i), b16(op_w[i]), b16(eo));
      chk($sformatf("d%0d op_last", i), b16(last_w[i]), b16(el));
      chk($sformatf("d%0d valid", i), b16(valid_w[i]), b16(ev));
      chk($sformatf("d%0d busy", i), b16(busy_w[i]), b16(eb));
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (phase[i] < 0) begin
        if (start_v[i] && !abort_v[i]) phase[i] = 1;
      end else if (abort_v[i]) begin
        phase[i] = -1;
      end else if (phase[i] < pn[i] + pc[i]) begin
        phase[i] = phase[i] + 1;
      end else if (ph[i] == 0 || ack_v[i]) begin
        phase[i] = -1;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clock);
    check_model();
  endtask

  task automatic fin();
    advance();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    at_neg();
    fin();
  endtask

  initial begin
    int cnt;
    logic [15:0] e;
    start_v = 3'b111; abort_v = '0; ack_v = '0;
    for (int i = 0; i < 3; i++) phase[i] = -1;

    // Outputs held low in reset even with start asserted.
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst d%0d capture", i), cap_o[i], 16'd0);
      chk($sformatf("rst d%0d op/valid/busy", i),
          {13'd0, op_w[i], valid_w[i], busy_w[i]}, 16'd0);
    end
    #9;
    start_v = '0;
    rst_n   = 1'b1;
    @(posedge clock);
    #1;

    // Default timeline.
    for (int k = 0; k < 7; k++) begin
      start_v[0] = (k == 0);
      at_neg();
      e = (k < 4) ? (16'd1 << k) : 16'd0;
      chk($sformatf("dflt capture k%0d", k), cap_o[0], e);
      chk($sformatf("dflt op k%0d", k), b16(op_w[0]), b16(k == 4));
      chk($sformatf("dflt valid k%0d", k), b16(valid_w[0]), b16(k == 5));
      chk($sformatf("dflt busy k%0d", k), b16(busy_w[0]), b16(k >= 1 && k <= 5));
      fin();
    end

    // Held valid, late ack, start ignored in DONE.
    for (int k = 0; k < 16; k++) begin
      start_v[1] = (k == 0) || (k == 10) || (k == 11);
      ack_v[1]   = (k == 13);
      at_neg();
      if (k == 8)  chk("hold op_last k8", b16(last_w[1]), 16'd1);
      if (k == 9)  chk("hold first valid", b16(valid_w[1]), 16'd1);
      if (k == 10 || k == 11) chk("start in done ignored", cap_o[1], 16'd0);
      if (k == 12) chk("hold valid k12", b16(valid_w[1]), 16'd1);
      if (k == 14) chk("hold release", {14'd0, valid_w[1], busy_w[1]}, 16'd0);
      fin();
    end
    start_v = '0; ack_v = '0;

    // Abort in cycle 2, restart in cycle 3.
    for (int k = 0; k < 10; k++) begin
      start_v[0] = (k == 0) || (k == 3);
      abort_v[0] = (k == 2);
      at_neg();
      if (k == 2) chk("abort capture", cap_o[0], 16'd0);
      if (k == 3) chk("restart capture", cap_o[0], 16'd1);
      fin();
    end
    start_v = '0; abort_v = '0;

    // start with abort in IDLE.
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    at_neg();
    chk("start+abort capture", cap_o[0], 16'd0);
    chk("start+abort busy", b16(busy_w[0]), 16'd0);
    fin();
    start_v = '0; abort_v = '0;
    at_neg();
    chk("start+abort stays idle", b16(busy_w[0]), 16'd0);
    fin();

    // Single-operand config with start held: new sequence every 3 cycles.
    cnt = 0;
    start_v[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      at_neg();
      if (cap_o[2] == 16'd1) cnt++;
      fin();
    end
    chk("held start sequences", 16'(cnt), 16'd4);
    start_v = '0;
    repeat (3) tick();

    // Asynchronous reset mid-OPERATE.
    for (int k = 0; k < 6; k++) begin
      start_v[1] = (k == 0);
      tick();
    end
    #1;
    chk("op before reset", b16(op_w[1]), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("op drops in reset", b16(op_w[1]), 16'd0);
    chk("busy drops in reset", b16(busy_w[1]), 16'd0);
    for (int i = 0; i < 3; i++) phase[i] = -1;
    @(posedge clock);
    #2;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    at_neg();
    chk("idle after reset", b16(busy_w[1]), 16'd0);
    fin();

    // Randomized traffic on all three configurations.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 3; i++) begin
        start_v[i] = ($urandom_range(0, 2) == 0);
        abort_v[i] = ($urandom_range(0, 15) == 0);
        ack_v[i]   = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    start_v = '0; abort_v = '0; ack_v = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
